// File: rtl/dec_crc_pkg.sv
// Shared types, default CRC parameters and the bitwise CRC fold used by the
// DEC receive-side checker (and by anything that needs a reference CRC).
package dec_crc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int          CRC_WIDTH_DEF = 32;
    localparam logic [31:0] POLY_DEF      = 32'h04C11DB7;
    localparam logic [31:0] INIT_DEF      = 32'hFFFF_FFFF;

    // Upper bounds for the fold helper; callers zero-extend into these.
    localparam int MAX_CRC_W   = 64;
    localparam int MAX_CHUNK_W = 512;

    // Folds the low chunk_w bits of chunk into a crc_w-bit CRC, MSB first.
    function automatic logic [MAX_CRC_W-1:0] crc_fold(
        input logic [MAX_CRC_W-1:0]   crc,
        input logic [MAX_CHUNK_W-1:0] chunk,
        input int                     crc_w,
        input int                     chunk_w,
        input logic [MAX_CRC_W-1:0]   poly
    );
        logic [MAX_CRC_W-1:0] c;
        logic [MAX_CRC_W-1:0] mask;
        logic                 fb;
        c    = crc;
        mask = (MAX_CRC_W'(1) << crc_w) - MAX_CRC_W'(1);
        for (int i = MAX_CHUNK_W - 1; i >= 0; i--) begin
            if (i < chunk_w) begin
                fb = c[crc_w-1] ^ chunk[i];
                c  = ((c << 1) ^ (fb ? poly : '0)) & mask;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/dec_crc_chunk_step.sv
// One CHUNK_WIDTH-bit CRC fold step: purely combinational wrapper around
// crc_fold, sized to the checker's CRC and chunk widths.
module dec_crc_chunk_step
    import dec_crc_pkg::*;
#(
    parameter int                   CRC_WIDTH   = CRC_WIDTH_DEF,
    parameter int                   CHUNK_WIDTH = 64,
    parameter logic [CRC_WIDTH-1:0] POLY        = CRC_WIDTH'(POLY_DEF)
) (
    input  logic [CRC_WIDTH-1:0]   crc_i,
    input  logic [CHUNK_WIDTH-1:0] chunk_i,
    output logic [CRC_WIDTH-1:0]   crc_o
);

    logic [MAX_CRC_W-1:0]   crc_ext;
    logic [MAX_CRC_W-1:0]   poly_ext;
    logic [MAX_CHUNK_W-1:0] chunk_ext;

    always_comb begin
        crc_ext                     = '0;
        crc_ext[CRC_WIDTH-1:0]      = crc_i;
        poly_ext                    = '0;
        poly_ext[CRC_WIDTH-1:0]     = POLY;
        chunk_ext                   = '0;
        chunk_ext[CHUNK_WIDTH-1:0]  = chunk_i;
        crc_o = CRC_WIDTH'(crc_fold(crc_ext, chunk_ext, CRC_WIDTH, CHUNK_WIDTH, poly_ext));
    end

endmodule

// File: rtl/dec_crc_checker.sv
// Receive-side CRC checker: captures a payload/checksum pair, recomputes the
// CRC one chunk per cycle, then holds the result until downstream accepts it.
module dec_crc_checker
    import dec_crc_pkg::*;
#(
    parameter int                   DATA_WIDTH  = 512,
    parameter int                   CRC_WIDTH   = CRC_WIDTH_DEF,
    parameter int                   CHUNK_WIDTH = 64,
    parameter logic [CRC_WIDTH-1:0] POLY        = CRC_WIDTH'(POLY_DEF),
    parameter logic [CRC_WIDTH-1:0] INIT        = '1,
    parameter int                   CNT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [CRC_WIDTH-1:0]  checksum_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [CRC_WIDTH-1:0]  checksum_o,
    output logic [CRC_WIDTH-1:0]  crc_o,
    output logic [CRC_WIDTH-1:0]  syndrome_o,
    output logic                  error_o,
    output logic [CNT_WIDTH-1:0]  pkt_cnt_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o
);

    localparam int              K        = DATA_WIDTH / CHUNK_WIDTH;
    localparam int              IDX_W    = (K > 1) ? $clog2(K) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

    state_e                state_q,    state_d;
    logic [DATA_WIDTH-1:0] data_q,     data_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic [CRC_WIDTH-1:0]  checksum_q, checksum_d;
    logic [CRC_WIDTH-1:0]  crc_q,      crc_d;
    logic [IDX_W-1:0]      idx_q,      idx_d;
    logic [CNT_WIDTH-1:0]  pkt_cnt_q,  pkt_cnt_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q,  err_cnt_d;
    logic [CRC_WIDTH-1:0]  crc_step;
    logic [CRC_WIDTH-1:0]  syndrome;

    dec_crc_chunk_step #(
        .CRC_WIDTH   (CRC_WIDTH),
        .CHUNK_WIDTH (CHUNK_WIDTH),
        .POLY        (POLY)
    ) u_step (
        .crc_i   (crc_q),
        .chunk_i (shift_q[DATA_WIDTH-1 -: CHUNK_WIDTH]),
        .crc_o   (crc_step)
    );

    assign syndrome = crc_q ^ checksum_q;

    always_comb begin
        // NOTE: every next-state signal is defaulted to its current value first,
        // so no path through the case below can infer a latch.
        state_d    = state_q;
        data_d     = data_q;
        shift_d    = shift_q;
        checksum_d = checksum_q;
        crc_d      = crc_q;
        idx_d      = idx_q;
        pkt_cnt_d  = pkt_cnt_q;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    data_d     = data_i;
                    checksum_d = checksum_i;
                    shift_d    = data_i;
                    crc_d      = INIT;
                    idx_d      = '0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                crc_d   = crc_step;
                shift_d = shift_q << CHUNK_WIDTH;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Statistics count delivered results only, on the handshake edge.
                if (ready_i) begin
                    state_d = IDLE;
                    if (pkt_cnt_q != '1) begin
                        pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
                    end
                    if ((syndrome != '0) && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            data_q     <= '0;
            shift_q    <= '0;
            checksum_q <= '0;
            crc_q      <= '0;
            idx_q      <= '0;
            pkt_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge value of the others, independent of statement order.
            state_q    <= state_d;
            data_q     <= data_d;
            shift_q    <= shift_d;
            checksum_q <= checksum_d;
            crc_q      <= crc_d;
            idx_q      <= idx_d;
            pkt_cnt_q  <= pkt_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign ready_o    = (state_q == IDLE);
    assign valid_o    = (state_q == DONE);
    assign data_o     = data_q;
    assign checksum_o = checksum_q;
    assign crc_o      = crc_q;
    assign syndrome_o = syndrome;
    assign error_o    = (syndrome != '0);
    assign pkt_cnt_o  = pkt_cnt_q;
    assign err_cnt_o  = err_cnt_q;

endmodule
